// File: rtl/ifm_window_feeder.sv
// 3x3 sliding-window operand feeder: raster pixel stream in, 9 ifm lanes + weights + bias out.
// Optional macro WIN_STRIDE2_EN restricts window emission to stride 2.
`timescale 1ns/1ps
module ifm_window_feeder #(
  parameter int INPUT_IFM_WIDTH  = 8,
  parameter int INPUT_WGT_WIDTH  = 8,
  parameter int INPUT_BIAS_WIDTH = 8,
  parameter int PE_ARR_SIZE      = 9,
  parameter int IFM_COLS         = 32,
  parameter int IFM_ROWS         = 32,
  parameter int PIPE_LAT         = 5
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic                                              wgt_wr_en,
  input  logic [3:0]                                        wgt_wr_addr,
  input  logic [INPUT_WGT_WIDTH-1:0]                        wgt_wr_data,
  input  logic                                              bias_wr_en,
  input  logic [INPUT_BIAS_WIDTH-1:0]                       bias_wr_data,
  input  logic                                              pix_valid,
  input  logic [INPUT_IFM_WIDTH-1:0]                        pix_data,
  output logic                                              pix_ready,
  output logic [PE_ARR_SIZE-1:0][INPUT_IFM_WIDTH-1:0]       ifm_output,
  output logic [PE_ARR_SIZE-1:0][INPUT_WGT_WIDTH-1:0]       wgt_output,
  output logic [INPUT_BIAS_WIDTH-1:0]                       bias_output,
  output logic                                              win_valid,
  output logic                                              ofm_valid,
  output logic                                              busy,
  output logic                                              frame_done
);

  if (PE_ARR_SIZE != 9) begin : g_bad_arr_size
    $error("ifm_window_feeder: PE_ARR_SIZE must be 9");
  end

  localparam int CW = (IFM_COLS > 1) ? $clog2(IFM_COLS) : 1;
  localparam int RW = (IFM_ROWS > 1) ? $clog2(IFM_ROWS) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IFM_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IFM_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CW-1:0]              r_col;
  logic [RW-1:0]              r_row;
  logic [DW-1:0]              r_drain;
  logic [PIPE_LAT-1:0]        r_ofm_sr;
  logic [INPUT_IFM_WIDTH-1:0] r_lb0 [IFM_COLS];
  logic [INPUT_IFM_WIDTH-1:0] r_lb1 [IFM_COLS];
  logic [INPUT_IFM_WIDTH-1:0] r_sh  [3][2];
  logic [INPUT_IFM_WIDTH-1:0] w_newcol [3];
  logic [PE_ARR_SIZE-1:0][INPUT_IFM_WIDTH-1:0] w_win;
  logic                       w_acc;
  logic                       w_last;
  logic                       w_hit;
  logic                       w_idle;

  assign w_idle    = (r_state == S_IDLE);
  assign pix_ready = (r_state == S_STREAM);
  assign busy      = !w_idle;
  assign w_acc     = pix_valid && pix_ready;
  assign w_last    = w_acc && (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign ofm_valid = r_ofm_sr[PIPE_LAT-1];

`ifdef WIN_STRIDE2_EN
  // r-2 / c-2 even is the same as r / c even
  assign w_hit = (r_row >= RW'(2)) && (r_col >= CW'(2)) && !r_row[0] && !r_col[0];
`else
  assign w_hit = (r_row >= RW'(2)) && (r_col >= CW'(2));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_drain == DW'(PIPE_LAT - 1)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_drain <= '0;
    end else begin
      if (w_idle && start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_acc && !w_last) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (r_state == S_DRAIN) r_drain <= r_drain + DW'(1);
      else                    r_drain <= '0;
    end
  end

  // Column c of rows r-2, r-1, r as seen when pixel (r,c) arrives
  always_comb begin
    w_newcol[0] = r_lb0[r_col];
    w_newcol[1] = r_lb1[r_col];
    w_newcol[2] = pix_data;
    w_win       = '0;
    for (int unsigned ky = 0; ky < 3; ky++) begin
      w_win[ky*3 + 0] = r_sh[ky][0];
      w_win[ky*3 + 1] = r_sh[ky][1];
      w_win[ky*3 + 2] = w_newcol[ky];
    end
  end

  // Data storage only; contents are qualified by win_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pix_data;
      for (int unsigned ky = 0; ky < 3; ky++) begin
        r_sh[ky][0] <= r_sh[ky][1];
        r_sh[ky][1] <= w_newcol[ky];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifm_output  <= '0;
      win_valid   <= 1'b0;
      r_ofm_sr    <= '0;
      frame_done  <= 1'b0;
      wgt_output  <= '0;
      bias_output <= '0;
    end else begin
      win_valid <= w_acc && w_hit;
      if (w_acc && w_hit) ifm_output <= w_win;
      r_ofm_sr[0] <= win_valid;
      for (int unsigned i = 1; i < PIPE_LAT; i++) r_ofm_sr[i] <= r_ofm_sr[i-1];
      frame_done <= (r_state == S_DONE);
      if (w_idle) begin
        if (wgt_wr_en && (wgt_wr_addr < 4'(PE_ARR_SIZE))) wgt_output[wgt_wr_addr] <= wgt_wr_data;
        if (bias_wr_en) bias_output <= bias_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_ifm_window_feeder.sv
// Randomized bench for ifm_window_feeder against a frame-level window model.
// Defining WIN_STRIDE2_EN switches the bench to the 5x5 stride-2 configuration.
`timescale 1ns/1ps
module tb_ifm_window_feeder;
`ifdef WIN_STRIDE2_EN
  localparam int N = 5, STRIDE = 2;
`else
  localparam int N = 4, STRIDE = 1;
`endif
  localparam int PL = 5;
  typedef logic [71:0] win_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic wgt_wr_en = 1'b0, bias_wr_en = 1'b0, pix_valid = 1'b0;
  logic [3:0] wgt_wr_addr = '0;
  logic [7:0] wgt_wr_data = '0, bias_wr_data = '0, pix_data = '0;
  logic pix_ready, win_valid, ofm_valid, busy, frame_done;
  logic [8:0][7:0] ifm_output, wgt_output;
  logic [7:0] bias_output;

  ifm_window_feeder #(
    .INPUT_IFM_WIDTH(8), .INPUT_WGT_WIDTH(8), .INPUT_BIAS_WIDTH(8),
    .PE_ARR_SIZE(9), .IFM_COLS(N), .IFM_ROWS(N), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .ifm_output(ifm_output), .wgt_output(wgt_output), .bias_output(bias_output),
    .win_valid(win_valid), .ofm_valid(ofm_valid), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_win = 0, n_ofm = 0, n_done = 0, last_ofm = -100;
  logic [7:0] pix [N*N];
  win_t exp_q [$];
  int   wcyc_q [$];
  win_t first_win, last_win;
  logic [8:0][7:0] exp_w = '0;
  logic [7:0] exp_bias = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every (r,c) with r,c >= 2 on the stride grid ends the window rows r-2..r, cols c-2..c
  task automatic build_expected();
    exp_q.delete();
    for (int r = 2; r < N; r++)
      for (int c = 2; c < N; c++)
        if (((r - 2) % STRIDE == 0) && ((c - 2) % STRIDE == 0)) begin
          win_t w = '0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              w[(ky*3 + kx)*8 +: 8] = pix[(r - 2 + ky)*N + (c - 2 + kx)];
          exp_q.push_back(w);
        end
  endtask

  function automatic win_t lit_win(input int a0, input int a1, input int a2, input int row_step);
    win_t w = '0;
    for (int ky = 0; ky < 3; ky++) begin
      w[(ky*3 + 0)*8 +: 8] = 8'(a0 + ky*row_step);
      w[(ky*3 + 1)*8 +: 8] = 8'(a1 + ky*row_step);
      w[(ky*3 + 2)*8 +: 8] = 8'(a2 + ky*row_step);
    end
    return w;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (win_valid) begin
        chk("window_expected", 128'(exp_q.size() > 0), 128'(1));
        if (n_win == 0) first_win = ifm_output;
        last_win = ifm_output;
        if (exp_q.size() > 0) chk("window_data", 128'(ifm_output), 128'(exp_q.pop_front()));
        n_win++;
        wcyc_q.push_back(cyc);
      end
      if (ofm_valid) begin
        chk("ofm_has_window", 128'(wcyc_q.size() > 0), 128'(1));
        if (wcyc_q.size() > 0) chk("ofm_latency", 128'(cyc - wcyc_q.pop_front()), 128'(PL));
        n_ofm++;
        last_ofm = cyc;
      end
      if (frame_done) begin
        n_done++;
        chk("done_after_last_ofm", 128'(cyc - last_ofm), 128'(1));
      end
    end
  end

  task automatic run_frame(input bit rnd, input bit bp, input bit mid_ctl,
                           input bit abort, input bit bias_at_start);
    int idx = 0, guard = 0, done0 = n_done, exp_cnt;
    for (int i = 0; i < N*N; i++) pix[i] = rnd ? 8'($urandom) : 8'(i);
    build_expected();
    wcyc_q.delete();
    exp_cnt = exp_q.size();
    n_win = 0; n_ofm = 0;
    start = 1'b1;
    if (bias_at_start) begin
      bias_wr_en = 1'b1; bias_wr_data = 8'h11; exp_bias = 8'h11;
    end
    @(posedge clk); #1;
    start = 1'b0; bias_wr_en = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 128'(busy), 128'(1));
    @(posedge clk); #1;
    while (idx < N*N && guard < 2000) begin
      pix_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = pix[idx];
      if (mid_ctl && idx == (N*N)/2) begin
        start = 1'b1; wgt_wr_en = 1'b1; wgt_wr_addr = 4'd0; wgt_wr_data = 8'h55;
        bias_wr_en = 1'b1; bias_wr_data = 8'h7F;
      end else begin
        start = 1'b0; wgt_wr_en = 1'b0; bias_wr_en = 1'b0;
      end
      @(negedge clk);
      if (pix_valid && pix_ready) idx++;
      @(posedge clk); #1;
      guard++;
      if (abort && idx == 10) begin
        pix_valid = 1'b0; start = 1'b0; wgt_wr_en = 1'b0; bias_wr_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete(); wcyc_q.delete();
        exp_w = '0; exp_bias = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_frame_done", 128'(n_done - done0), 128'(0));
        chk("abort_idle", 128'(busy), 128'(0));
        chk("abort_wgt_cleared", 128'(wgt_output), 128'(exp_w));
        return;
      end
    end
    pix_valid = 1'b0; start = 1'b0; wgt_wr_en = 1'b0; bias_wr_en = 1'b0;
    chk("pixels_accepted", 128'(idx), 128'(N*N));
    guard = 0;
    while (n_done == done0 && guard < 40) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("frame_done_seen", 128'(n_done - done0), 128'(1));
    chk("idle_at_done", 128'(busy), 128'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("frame_done_once", 128'(n_done - done0), 128'(1));
    chk("window_count", 128'(n_win), 128'(exp_cnt));
    chk("ofm_count", 128'(n_ofm), 128'(exp_cnt));
    chk("windows_left", 128'(exp_q.size()), 128'(0));
    chk("weights_kept", 128'(wgt_output), 128'(exp_w));
    chk("bias_kept", 128'(bias_output), 128'(exp_bias));
  endtask

  task automatic check_literal_frame();
`ifdef WIN_STRIDE2_EN
    chk("first_window", 128'(first_win), 128'(lit_win(0, 1, 2, 5)));
    chk("last_window", 128'(last_win), 128'(lit_win(12, 13, 14, 5)));
    chk("stride_count", 128'(n_win), 128'(4));
`else
    chk("first_window", 128'(first_win), 128'(lit_win(0, 1, 2, 4)));
    chk("last_window", 128'(last_win), 128'(lit_win(5, 6, 7, 4)));
    chk("win_count4", 128'(n_win), 128'(4));
`endif
  endtask

  initial begin
    // reset with start and pix_valid asserted
    pix_valid = 1'b1; start = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_ifm", 128'(ifm_output), 128'(0));
    chk("rst_wgt", 128'(wgt_output), 128'(0));
    chk("rst_bias", 128'(bias_output), 128'(0));
    chk("rst_ctrl", 128'({pix_ready, win_valid, ofm_valid, busy, frame_done}), 128'(0));
    @(posedge clk); #1;
    pix_valid = 1'b0; start = 1'b0; rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      wgt_wr_en = 1'b1; wgt_wr_addr = 4'(i); wgt_wr_data = 8'(i + 1);
      exp_w[i] = 8'(i + 1);
      bias_wr_en = (i == 0); bias_wr_data = 8'hFD;
      @(posedge clk); #1;
    end
    exp_bias = 8'hFD;
    bias_wr_en = 1'b0;
    wgt_wr_addr = 4'd12; wgt_wr_data = 8'h7F;
    @(posedge clk); #1;
    wgt_wr_en = 1'b0;
    @(negedge clk);
    chk("cfg_weights", 128'(wgt_output), 128'(exp_w));
    chk("cfg_bias", 128'(bias_output), 128'(8'hFD));
    @(posedge clk); #1;

    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_literal_frame();
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_literal_frame();
    run_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_literal_frame();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "simulation time limit");
  end
endmodule
